// File: rtl/rhythm_core.sv
// Play engine for one game round: pseudo-random target lane, tick-timed response
// window, hit/miss/round counters and a one-clk stop_tag when the game ends.
module rhythm_core #(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned ROUNDS   = 20,
  parameter int unsigned MAX_MISS = 5,
  parameter int unsigned BASE_WIN = 1000,
  parameter int unsigned GAP      = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic       lvl_btn,
  input  logic [3:0] hit,
  output logic       stop_tag,
  output logic [1:0] lane,
  output logic       lane_valid,
  output logic [1:0] level,
  output logic [7:0] score,
  output logic [7:0] miss_cnt,
  output logic [7:0] round_cnt
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GW = $clog2(GAP + 1);
  localparam int unsigned WW = $clog2(BASE_WIN + 1);

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_PLAY  = 3'b001;
  localparam logic [2:0] ST_SPEED = 3'b100;

  typedef enum logic [1:0] {G_IDLE, G_GAP, G_SHOW, G_DONE} eng_e;

  eng_e          eng_q;
  logic [PW-1:0] presc_q;
  logic [7:0]    lfsr_q;
  logic [GW-1:0] gap_q;
  logic [WW-1:0] win_q;
  logic [1:0]    lane_q;
  logic          lane_valid_q;
  logic [1:0]    level_q;
  logic [7:0]    score_q;
  logic [7:0]    miss_q;
  logic [7:0]    round_q;
  logic          stop_q;

  logic          play_c;
  logic          counting_c;
  logic          tick_en_c;
  logic [7:0]    lfsr_d;
  logic [WW-1:0] win_len_c;
  logic          hit_ok_c;
  logic          end_c;
  logic [7:0]    score_d;
  logic [7:0]    miss_d;
  logic [7:0]    round_d;
  logic          finish_c;

  // Tick generation, window sizing and round-outcome decode
  always_comb begin
    play_c     = (state == ST_PLAY);
    counting_c = play_c && ((eng_q == G_GAP) || (eng_q == G_SHOW));
    tick_en_c  = counting_c && (presc_q == PW'(TICK_DIV - 1));
    lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    win_len_c  = WW'(BASE_WIN >> level_q);
    hit_ok_c   = (hit == (4'b0001 << lane_q));
    // A press on the final window tick takes priority over the timeout
    end_c      = (hit != 4'b0000) || (tick_en_c && (win_q == WW'(1)));
    score_d    = score_q;
    miss_d     = miss_q;
    if (hit_ok_c) begin
      score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
    end else begin
      miss_d = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;
    end
    round_d  = (round_q == 8'hFF) ? round_q : round_q + 8'd1;
    finish_c = (round_d == 8'(ROUNDS)) || (miss_d == 8'(MAX_MISS));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_q        <= G_IDLE;
      presc_q      <= '0;
      lfsr_q       <= 8'h01;
      gap_q        <= '0;
      win_q        <= '0;
      lane_q       <= 2'd0;
      lane_valid_q <= 1'b0;
      level_q      <= 2'd0;
      score_q      <= 8'd0;
      miss_q       <= 8'd0;
      round_q      <= 8'd0;
      stop_q       <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      stop_q  <= 1'b0;
      presc_q <= (counting_c && !tick_en_c) ? presc_q + PW'(1) : '0;
      if ((state == ST_SPEED) && lvl_btn) begin
        level_q <= level_q + 2'd1;
      end
      // Idle always pulls the engine home; counters clear once it is there
      if (state == ST_IDLE) begin
        lane_valid_q <= 1'b0;
        eng_q        <= G_IDLE;
        if (eng_q == G_IDLE) begin
          score_q <= 8'd0;
          miss_q  <= 8'd0;
          round_q <= 8'd0;
        end
      end else begin
        case (eng_q)
          G_IDLE: begin
            if (play_c) begin
              gap_q <= GW'(GAP);
              eng_q <= G_GAP;
            end
          end
          G_GAP: begin
            if (tick_en_c) begin
              if (gap_q == GW'(1)) begin
                lane_q       <= lfsr_q[1:0];
                lane_valid_q <= 1'b1;
                win_q        <= win_len_c;
                eng_q        <= G_SHOW;
              end else begin
                gap_q <= gap_q - GW'(1);
              end
            end
          end
          G_SHOW: begin
            if (play_c) begin
              if (end_c) begin
                lane_valid_q <= 1'b0;
                score_q      <= score_d;
                miss_q       <= miss_d;
                round_q      <= round_d;
                if (finish_c) begin
                  stop_q <= 1'b1;
                  eng_q  <= G_DONE;
                end else begin
                  gap_q <= GW'(GAP);
                  eng_q <= G_GAP;
                end
              end else if (tick_en_c) begin
                win_q <= win_q - WW'(1);
              end
            end
          end
          G_DONE: begin
            eng_q <= G_DONE;
          end
          default: begin
            eng_q <= G_IDLE;
          end
        endcase
      end
    end
  end

  assign stop_tag   = stop_q;
  assign lane       = lane_q;
  assign lane_valid = lane_valid_q;
  assign level      = level_q;
  assign score      = score_q;
  assign miss_cnt   = miss_q;
  assign round_cnt  = round_q;

endmodule

// File: doc/rhythm_core.md
Name: rhythm_core

Overview:
- Play engine that runs one game round while the top-level game FSM is in its play state.
- Presents a pseudo-random target lane and times the player's response window.
- Counts hits and misses, and raises stop_tag to end the play state.
- Sits directly upstream of the game FSM, which consumes stop_tag. It also feeds the score/miss display logic with its counters.

Parameters:
- TICK_DIV, 100000: clk cycles per game tick (1 kHz at 100 MHz).
- ROUNDS, 20: targets per game.
- MAX_MISS, 5: miss count that ends the game early.
- BASE_WIN, 1000: response window in ticks at level 0.
- GAP, 200: blank ticks before each target.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-high reset.
- state, input, 3: game FSM state. Encodings: idle=000, play=001, stop=010, score=011, speed=100, miss=101.
- lvl_btn, input, 1: one-cycle pulse (already debounced) that steps the speed level.
- hit, input, 4: one-cycle lane button pulses (already debounced), bit n = lane n.
- stop_tag, output, 1: one-cycle pulse when the game ends.
- lane, output, 2: current target lane.
- lane_valid, output, 1: target is showing.
- level, output, 2: speed level 0..3.
- score, output, 8: hit count.
- miss_cnt, output, 8: miss count.
- round_cnt, output, 8: targets completed.

Behaviour:
- Reset (asynchronous, rst high): all outputs 0; internal engine state G_IDLE; prescaler 0; LFSR 8'h01.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every clk in all states and never reaches 0. Lane is taken from lfsr[1:0] at target load.
- Prescaler counts only while state==play and the engine is in G_GAP or G_SHOW; otherwise it is held at 0.
  - tick_en is high for one clk when the prescaler reaches TICK_DIV-1; the prescaler then wraps to 0.
- Level: when state==speed and lvl_btn=1, level <= level+1, wrapping 3->0. In all other states level holds. Level is not cleared by idle.
- Window length W = BASE_WIN >> level, i.e. 1000/500/250/125 ticks.
- Engine states:
  - G_IDLE:
    - If state==idle: clear score, miss_cnt, round_cnt; lane_valid=0.
    - If state==play: load gap counter with GAP and go to G_GAP.
  - G_GAP:
    - On each tick_en, decrement the gap counter.
    - At the tick where the counter equals 1: go to G_SHOW, lane <= lfsr[1:0], lane_valid <= 1, load window counter with W.
    - hit pulses are ignored in G_GAP (no penalty).
  - G_SHOW: first matching condition wins.
    - (a) hit == one-hot of lane: score+1.
    - (b) hit != 0 otherwise (wrong lane, or more than one bit set): miss_cnt+1.
    - (c) tick_en and window counter==1: timeout, miss_cnt+1.
    - (d) tick_en: decrement window counter.
    - On (a), (b) or (c), in the same clk:
      - lane_valid <= 0 and round_cnt+1.
      - If the new round_cnt==ROUNDS or the new miss_cnt==MAX_MISS: go to G_DONE and assert stop_tag for exactly 1 clk.
      - Otherwise load GAP and go to G_GAP.
  - G_DONE:
    - Counters hold for display during stop/score/miss.
    - Go to G_IDLE when state==idle; counters clear on the following clk, per G_IDLE.
- If state leaves play while in G_GAP or G_SHOW (not reachable through the game FSM): engine freezes, since the prescaler is held.
  - If state==idle in any engine state: return to G_IDLE, lane_valid=0.
- A hit in the same clk as the timeout tick counts as a hit or wrong press (rules a/b); the timeout is not applied.
- Counters are 8-bit and saturate at 8'hFF.
- stop_tag is never asserted outside the transition into G_DONE.
- Reset mid-game: immediate return to reset values, no stop_tag.

Test Plan:
- Bench parameters: TICK_DIV=2, GAP=3, BASE_WIN=8, ROUNDS=4, MAX_MISS=2.
- 1. Level stepping: hold state=speed, pulse lvl_btn 5x -> level 0,1,2,3,0,1. Then state=idle, pulse lvl_btn -> level stays 1.
- 2. Correct hits: state=play, level 0. After each lane_valid rise, pulse hit=one-hot(lane) -> score 1..4, miss_cnt 0, round_cnt=4. stop_tag high 1 clk on the 4th hit; lane_valid 0.
- 3. Timeouts: state=play, never press. Each target times out 16 clk after lane_valid rises (W=8 ticks) -> miss_cnt 1 then 2. stop_tag on the 2nd timeout with round_cnt=2, score=0.
- 4. Wrong lane and gap press:
  - hit during G_GAP -> no counter change.
  - hit=4'b0011 during G_SHOW -> miss_cnt+1.
  - hit on the same clk as the final window tick -> scored per rules a/b, not a timeout.
- 5. Level 3 window: W=1 tick, so lane_valid is high for 2 clk before the timeout miss.
- 6. Clear and reset: after a game ends, state=stop -> counters hold; state=idle -> score/miss_cnt/round_cnt = 0. Assert rst during G_SHOW -> all outputs 0 immediately, no stop_tag pulse.
